match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL provide parameter FRAME_DIV, default 833333, clock cycles per physics frame tick (minimum 2).
REQ-002 SHALL provide parameter PAUSE_FRAMES, default 60, frame ticks frozen after each point (1..255).
REQ-003 SHALL provide parameter WIN_SCORE, default 15, points needed to win the match (1..31).
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit, single-cycle pulse that starts a match.
REQ-007 SHALL have port phys_valid, input, 1 bit, physics update-complete flag.
REQ-008 SHALL have port phys_game_over, input, 1 bit, ball-landed flag from physics.
REQ-009 SHALL have port phys_winner, input, 2 bits, point winner: 1 = P1, 2 = P2; 0 and 3 are invalid.
REQ-010 SHALL have port phys_en, output, 1 bit, one-cycle physics enable pulse.
REQ-011 SHALL have ports p1_score and p2_score, output, 5 bits each, current scores.
REQ-012 SHALL have port state, output, 2 bits, encoded as 0 = IDLE, 1 = PLAY, 2 = PAUSE, 3 = OVER.
REQ-013 SHALL have port match_winner, output, 2 bits: 0 = none, 1 = P1, 2 = P2.

Function
REQ-014 SHALL run a free-running frame counter 0..FRAME_DIV-1 that wraps to 0; frame_tick is true when count == FRAME_DIV-1.
REQ-015 SHALL assert phys_en for exactly the cycle after each frame_tick, and only when state == PLAY during that tick.
REQ-016 IDLE: on start, go to PLAY and clear both scores and match_winner; all other inputs are ignored.
REQ-017 PLAY: a point event is phys_valid && phys_game_over && (phys_winner == 1 or phys_winner == 2); on the next cycle, increment the winner's score.
REQ-018 PLAY: phys_game_over with phys_winner of 0 or 3 SHALL be ignored, with no score change and no state change.
REQ-019 PLAY, after a point event: if the new score meets the win rule, go to OVER and set match_winner; otherwise go to PAUSE and load the pause counter with PAUSE_FRAMES.
REQ-020 PAUSE: decrement the pause counter on each frame_tick; when it reaches 0, go to PLAY. No phys_en is issued while paused.
REQ-021 OVER: hold the scores and match_winner; on start, go to PLAY with scores and match_winner cleared.
REQ-022 start SHALL be ignored in PLAY and PAUSE.
REQ-023 Point events arriving outside PLAY SHALL be ignored.
REQ-024 At most one point SHALL be counted per point-event cycle; if consecutive cycles carry a point event, only the first counts, because state has already left PLAY.
REQ-025 Scores SHALL never exceed 31. A point that would bring a score to 31 forces OVER with that player as match_winner.

Reset
REQ-026 When rst is sampled high: state = IDLE; frame counter = 0; pause counter = 0; p1_score = p2_score = 0; match_winner = 0; phys_en = 0.
REQ-027 Reset asserted mid-PAUSE or mid-PLAY SHALL abandon the match with no score retained.

Configuration
REQ-028 Macro MATCH_DEUCE_EN. When defined, the win rule is score >= WIN_SCORE and a lead of at least 2 over the opponent, with the 31 cap from REQ-025 still applying. When undefined, the win rule is score == WIN_SCORE.

Verification (FRAME_DIV=4, PAUSE_FRAMES=3, WIN_SCORE=3)
REQ-029 Assert rst, then hold start=1 for 1 cycle -> state=1; phys_en pulses every 4 cycles; scores 0/0.
REQ-030 In PLAY, drive phys_valid=1, phys_game_over=1, phys_winner=2 -> p2_score=1 and state=2; after 3 frame ticks state=1; no phys_en during the pause.
REQ-031 Drive game_over with phys_winner=0, and separately with phys_winner=3 -> no score change, state stays 1.
REQ-032 Award P1 three points -> p1_score=3, state=3, match_winner=1. A later start pulse gives 0/0, state=1, match_winner=0.
REQ-033 With MATCH_DEUCE_EN defined, at 2/2 award P1 one point -> 3/2 and state=2, not 3. Award P1 again -> 4/2, state=3, match_winner=1.
REQ-034 Pulse rst during PAUSE at score 2/1 -> next cycle state=0, scores 0/0, phys_en=0.

Source files
------------

// File: rtl/match_ctrl.sv
// match_ctrl: match sequencing for a two-player ball game.
// Divides the system clock into physics frames, gates the physics engine
// with a one-cycle enable, keeps both scores, freezes play for a few frames
// after every point and declares the match winner.
// Optional feature macro: MATCH_DEUCE_EN (win by two, still capped at 31).

module match_ctrl #(
    parameter int FRAME_DIV    = 833333,
    parameter int PAUSE_FRAMES = 60,
    parameter int WIN_SCORE    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       phys_valid,
    input  logic       phys_game_over,
    input  logic [1:0] phys_winner,
    output logic       phys_en,
    output logic [4:0] p1_score,
    output logic [4:0] p2_score,
    output logic [1:0] state,
    output logic [1:0] match_winner
);

    localparam int              CW         = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0]   FRAME_LAST = CW'(FRAME_DIV - 1);
    localparam logic [4:0]      WIN5       = 5'(WIN_SCORE);
    localparam logic [4:0]      SCORE_MAX  = 5'd31;
    localparam logic [7:0]      PAUSE_LOAD = 8'(PAUSE_FRAMES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [CW-1:0] frame_cnt;
    logic          frame_tick;
    logic [7:0]    pause_cnt;
    logic [7:0]    pause_nxt;
    logic [4:0]    p1_nxt;
    logic [4:0]    p2_nxt;
    logic [1:0]    winner_nxt;
    logic          point_evt;
    logic [4:0]    p1_inc;
    logic [4:0]    p2_inc;

    // A score can only be incremented from PLAY, and reaching 31 always
    // ends the match, so these +1 results never wrap.
    assign frame_tick = (frame_cnt == FRAME_LAST);
    assign point_evt  = phys_valid && phys_game_over &&
                        ((phys_winner == 2'd1) || (phys_winner == 2'd2));
    assign p1_inc     = p1_score + 5'd1;
    assign p2_inc     = p2_score + 5'd1;
    assign state      = cur_state;

    // Decides whether a freshly incremented score ends the match.
    function automatic logic wins(input logic [4:0] mine, input logic [4:0] opp);
`ifdef MATCH_DEUCE_EN
        wins = (mine == SCORE_MAX) ||
               ((mine >= WIN5) && ({1'b0, mine} >= ({1'b0, opp} + 6'd2)));
`else
        wins = (mine == WIN5) || (mine == SCORE_MAX);
`endif
    endfunction

    // Free-running frame divider; the tick is its last count.
    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_tick)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 1'b1;
    end

    // Physics enable follows a frame tick by one cycle, only while playing.
    always_ff @(posedge clk) begin
        if (rst)
            phys_en <= 1'b0;
        else
            phys_en <= frame_tick && (cur_state == PLAY);
    end

    // Match state, scores, winner and pause counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= IDLE;
            pause_cnt    <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            match_winner <= 2'd0;
        end else begin
            cur_state    <= nxt_state;
            pause_cnt    <= pause_nxt;
            p1_score     <= p1_nxt;
            p2_score     <= p2_nxt;
            match_winner <= winner_nxt;
        end
    end

    // Next-state logic: start pulses, point scoring and pause countdown.
    always_comb begin
        nxt_state  = cur_state;
        pause_nxt  = pause_cnt;
        p1_nxt     = p1_score;
        p2_nxt     = p2_score;
        winner_nxt = match_winner;

        case (cur_state)
            IDLE, OVER: begin
                if (start) begin
                    nxt_state  = PLAY;
                    p1_nxt     = '0;
                    p2_nxt     = '0;
                    winner_nxt = 2'd0;
                    pause_nxt  = '0;
                end
            end

            PLAY: begin
                if (point_evt) begin
                    if (phys_winner == 2'd1) begin
                        p1_nxt = p1_inc;
                        if (wins(p1_inc, p2_score)) begin
                            nxt_state  = OVER;
                            winner_nxt = 2'd1;
                        end else begin
                            nxt_state = PAUSE;
                            pause_nxt = PAUSE_LOAD;
                        end
                    end else begin
                        p2_nxt = p2_inc;
                        if (wins(p2_inc, p1_score)) begin
                            nxt_state  = OVER;
                            winner_nxt = 2'd2;
                        end else begin
                            nxt_state = PAUSE;
                            pause_nxt = PAUSE_LOAD;
                        end
                    end
                end
            end

            PAUSE: begin
                if (frame_tick) begin
                    if (pause_cnt <= 8'd1) begin
                        pause_nxt = '0;
                        nxt_state = PLAY;
                    end else begin
                        pause_nxt = pause_cnt - 8'd1;
                    end
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed scenarios plus random traffic for match_ctrl,
// checked every cycle against a score-keeping reference model.

module tb_match_ctrl;

    localparam int FD = 4;
    localparam int PF = 3;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       phys_valid = 1'b0;
    logic       phys_game_over = 1'b0;
    logic [1:0] phys_winner = 2'd0;
    logic       phys_en;
    logic [4:0] p1_score;
    logic [4:0] p2_score;
    logic [1:0] state;
    logic [1:0] match_winner;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers describing the match.
    bit m_valid = 1'b0;
    int m_cnt;
    int m_state;
    int m_sc[2];
    int m_win;
    int m_pause;
    int m_en;
    int m_tick;
    int m_who;

    match_ctrl #(
        .FRAME_DIV(FD),
        .PAUSE_FRAMES(PF),
        .WIN_SCORE(WS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .phys_valid(phys_valid),
        .phys_game_over(phys_game_over),
        .phys_winner(phys_winner),
        .phys_en(phys_en),
        .p1_score(p1_score),
        .p2_score(p2_score),
        .state(state),
        .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input logic g, input logic [1:0] w);
        @(negedge clk);
        rst            = r;
        start          = s;
        phys_valid     = v;
        phys_game_over = g;
        phys_winner    = w;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic waitPlay();
        int n;
        n = 0;
        while (state != 2'd1 && n < 40) begin
            idleCycle();
            n++;
        end
        if (state != 2'd1)
            checkOutput("wait_play_timeout", 32'(state), 32'd1);
    endtask

    task automatic awardPoint(input logic [1:0] w);
        waitPlay();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, w);
        idleCycle();
    endtask

    function automatic bit modelWins(input int mine, input int opp);
`ifdef MATCH_DEUCE_EN
        return (mine == 31) || (mine >= WS && mine - opp >= 2);
`else
        return (mine == WS) || (mine == 31);
`endif
    endfunction

    // Advance the reference match by one clock using the sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_cnt   = 0;
            m_state = 0;
            m_sc[0] = 0;
            m_sc[1] = 0;
            m_win   = 0;
            m_pause = 0;
            m_en    = 0;
        end else if (m_valid) begin
            m_tick = (m_cnt == FD - 1) ? 1 : 0;
            m_en   = (m_tick == 1 && m_state == 1) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % FD;
            case (m_state)
                0, 3: begin
                    if (start) begin
                        m_state = 1;
                        m_sc[0] = 0;
                        m_sc[1] = 0;
                        m_win   = 0;
                    end
                end
                1: begin
                    if (phys_valid && phys_game_over &&
                        (phys_winner == 2'd1 || phys_winner == 2'd2)) begin
                        m_who = int'(phys_winner) - 1;
                        m_sc[m_who] = m_sc[m_who] + 1;
                        if (modelWins(m_sc[m_who], m_sc[1 - m_who])) begin
                            m_state = 3;
                            m_win   = int'(phys_winner);
                        end else begin
                            m_state = 2;
                            m_pause = PF;
                        end
                    end
                end
                default: begin
                    if (m_tick == 1) begin
                        m_pause = m_pause - 1;
                        if (m_pause == 0)
                            m_state = 1;
                    end
                end
            endcase
        end
    end

    // Compare every registered output against the model each cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_state", 32'(state), m_state);
            checkOutput("model_p1", 32'(p1_score), m_sc[0]);
            checkOutput("model_p2", 32'(p2_score), m_sc[1]);
            checkOutput("model_winner", 32'(match_winner), m_win);
            checkOutput("model_phys_en", 32'(phys_en), m_en);
        end
    end

    // Directed scenarios with literal expectations, then random traffic.
    initial begin
        int en_count;
        int n;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        idleCycle();
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_p1", 32'(p1_score), 32'd0);
        checkOutput("reset_p2", 32'(p2_score), 32'd0);
        checkOutput("reset_winner", 32'(match_winner), 32'd0);
        checkOutput("reset_phys_en", 32'(phys_en), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        idleCycle();
        checkOutput("start_state", 32'(state), 32'd1);
        en_count = 0;
        for (int i = 0; i < 8; i++) begin
            idleCycle();
            if (phys_en) en_count++;
        end
        checkOutput("phys_en_rate", en_count, 32'd2);
        checkOutput("start_scores", {27'd0, p1_score} + {27'd0, p2_score}, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        idleCycle();
        checkOutput("winner0_state", 32'(state), 32'd1);
        checkOutput("winner0_p2", 32'(p2_score), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
        idleCycle();
        checkOutput("winner3_state", 32'(state), 32'd1);
        checkOutput("winner3_p1", 32'(p1_score), 32'd0);

        awardPoint(2'd2);
        checkOutput("p2_point_score", 32'(p2_score), 32'd1);
        checkOutput("p2_point_state", 32'(state), 32'd2);
        en_count = 0;
        n = 0;
        while (state == 2'd2 && n < 40) begin
            idleCycle();
            n++;
            if (state == 2'd2 && phys_en) en_count++;
        end
        checkOutput("pause_no_phys_en", en_count, 32'd0);
        checkOutput("pause_ends_play", 32'(state), 32'd1);

        awardPoint(2'd1);
        awardPoint(2'd1);
        awardPoint(2'd1);
        checkOutput("p1_win_score", 32'(p1_score), 32'd3);
        checkOutput("p1_win_state", 32'(state), 32'd3);
        checkOutput("p1_win_winner", 32'(match_winner), 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        idleCycle();
        checkOutput("restart_state", 32'(state), 32'd1);
        checkOutput("restart_p1", 32'(p1_score), 32'd0);
        checkOutput("restart_winner", 32'(match_winner), 32'd0);

`ifdef MATCH_DEUCE_EN
        awardPoint(2'd1);
        awardPoint(2'd2);
        awardPoint(2'd1);
        awardPoint(2'd2);
        awardPoint(2'd1);
        checkOutput("deuce_p1", 32'(p1_score), 32'd3);
        checkOutput("deuce_state", 32'(state), 32'd2);
        awardPoint(2'd1);
        checkOutput("deuce_win_p1", 32'(p1_score), 32'd4);
        checkOutput("deuce_win_state", 32'(state), 32'd3);
        checkOutput("deuce_win_winner", 32'(match_winner), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        idleCycle();
`endif

        awardPoint(2'd1);
        awardPoint(2'd2);
        awardPoint(2'd1);
        checkOutput("pre_rst_p1", 32'(p1_score), 32'd2);
        checkOutput("pre_rst_p2", 32'(p2_score), 32'd1);
        checkOutput("pre_rst_state", 32'(state), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        idleCycle();
        checkOutput("pause_rst_state", 32'(state), 32'd0);
        checkOutput("pause_rst_scores", {27'd0, p1_score} + {27'd0, p2_score}, 32'd0);
        checkOutput("pause_rst_phys_en", 32'(phys_en), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 29) == 0,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) == 0,
                          2'($urandom_range(0, 3)));
        end
        idleCycle();
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
